// File: rtl/cpu_step_ctrl_if.sv
// cpu_step_ctrl_if: run-control bundle between the button front end and cpu_step_ctrl
// master drives the pulses and brk_hit; slave returns cpu_ce, running, busy and step_count.
interface cpu_step_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             step_pulse;
  logic             burst_pulse;
  logic             run_pulse;
  logic             brk_hit;
  logic             cpu_ce;
  logic             running;
  logic             busy;
  logic [CNT_W-1:0] step_count;
  modport master (
    output step_pulse, burst_pulse, run_pulse, brk_hit,
    input  cpu_ce, running, busy, step_count
  );
  modport slave (
    input  step_pulse, burst_pulse, run_pulse, brk_hit,
    output cpu_ce, running, busy, step_count
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns debounced button pulses into the RV32I core clock-enable
// clk/rst: system clock and synchronous active-high reset.
// io (slave): step/burst/run pulses and brk_hit in; registered cpu_ce, running, busy, step_count out.
module cpu_step_ctrl #(
  parameter int BURST_LEN = 16,
  parameter int RUN_DIV   = 1,
  parameter int CNT_W     = 32
) (
  input logic            clk,
  input logic            rst,
  cpu_step_ctrl_if.slave io
);
  typedef enum logic [1:0] {IDLE, STEP, BURST, RUN} state_t;
  localparam logic [15:0] BURST_MAX = 16'(BURST_LEN - 1);
  localparam logic [23:0] DIV_MAX   = 24'(RUN_DIV - 1);
  state_t           state_q, state_d;
  logic [15:0]      bcnt_q, bcnt_d;
  logic [23:0]      div_q, div_d;
  logic             seen_q, seen_d;
  logic             ce_q, ce_d;
  logic             running_q, running_d;
  logic             busy_q, busy_d;
  logic             brk;
  logic [CNT_W-1:0] count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      div_q     <= '0;
      seen_q    <= 1'b0;
      ce_q      <= 1'b0;
      running_q <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      div_q     <= div_d;
      seen_q    <= seen_d;
      ce_q      <= ce_d;
      running_q <= running_d;
      busy_q    <= busy_d;
      count_q   <= count_q + CNT_W'(ce_q);
    end
  end
  // A breakpoint only stops an episode once it has issued an enable (this cycle or earlier),
  // so the user can resume from a PC that still matches.
  assign brk = (state_q == BURST || state_q == RUN) && io.brk_hit && (ce_q || seen_q);
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    div_d   = div_q;
    seen_d  = seen_q | ce_q;
    unique case (state_q)
      IDLE: begin
        if (io.run_pulse) begin
          state_d = RUN;
          div_d   = '0;
          seen_d  = 1'b0;
        end else if (io.burst_pulse) begin
          state_d = BURST;
          bcnt_d  = '0;
          seen_d  = 1'b0;
        end else if (io.step_pulse) begin
          state_d = STEP;
        end
      end
      STEP: state_d = IDLE;
      BURST: begin
        if (brk) begin
          state_d = IDLE;
        end else if (io.run_pulse) begin
          state_d = RUN;
          div_d   = '0;
          seen_d  = 1'b0;
        end else if (bcnt_q == BURST_MAX) begin
          state_d = IDLE;
        end else begin
          bcnt_d = bcnt_q + 16'd1;
        end
      end
      RUN: begin
        state_d = (brk || io.run_pulse) ? IDLE : RUN;
        div_d   = (div_q == DIV_MAX) ? '0 : div_q + 24'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Enables fire when the divider lands on its last count, giving the first one RUN_DIV cycles after entry.
  always_comb begin
    ce_d      = state_d == STEP || state_d == BURST || (state_d == RUN && div_d == DIV_MAX);
    running_d = state_d == RUN;
    busy_d    = state_d == BURST;
  end
  assign io.cpu_ce     = ce_q;
  assign io.running    = running_q;
  assign io.busy       = busy_q;
  assign io.step_count = count_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: scoreboard bench for cpu_step_ctrl on two parameter sets
module tb_cpu_step_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        all_hi = 1'b0;
  logic        s = 1'b0, b = 1'b0, r = 1'b0, k = 1'b0;
  logic [34:0] obs, want;
  logic [31:0] e_cnt [2];
  logic [34:0] sb [$];
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  cpu_step_ctrl_if #(.CNT_W(32)) ia ();
  cpu_step_ctrl_if #(.CNT_W(4))  ib ();
  assign ia.step_pulse  = all_hi | (s & ~sel);
  assign ia.burst_pulse = all_hi | (b & ~sel);
  assign ia.run_pulse   = all_hi | (r & ~sel);
  assign ia.brk_hit     = all_hi | (k & ~sel);
  assign ib.step_pulse  = all_hi | (s & sel);
  assign ib.burst_pulse = all_hi | (b & sel);
  assign ib.run_pulse   = all_hi | (r & sel);
  assign ib.brk_hit     = all_hi | (k & sel);
  cpu_step_ctrl #(.BURST_LEN(16), .RUN_DIV(4), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .io(ia.slave));
  cpu_step_ctrl #(.BURST_LEN(8),  .RUN_DIV(1), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .io(ib.slave));
  assign obs = sel ? {ib.cpu_ce, ib.running, ib.busy, 28'd0, ib.step_count}
                   : {ia.cpu_ce, ia.running, ia.busy, ia.step_count};
  // Expected outputs for the next cycle; the count seen is the number of enables strictly before it.
  task automatic push(input logic ce, input logic run, input logic bsy);
    sb.push_back({ce, run, bsy, sel ? {28'd0, e_cnt[1][3:0]} : e_cnt[0]});
    e_cnt[sel] = e_cnt[sel] + 32'(ce);
  endtask
  task automatic step(input logic si, input logic bi, input logic ri, input logic ki);
    s = si; b = bi; r = ri; k = ki;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    all_hi = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total += 2;
      if ({ia.cpu_ce, ia.running, ia.busy, ia.step_count} !== 35'd0) begin
        bad++;
        $display("FAIL reset_a i=%0d got=%h want=0", i, {ia.cpu_ce, ia.running, ia.busy, ia.step_count});
      end
      if ({ib.cpu_ce, ib.running, ib.busy, ib.step_count} !== 7'd0) begin
        bad++;
        $display("FAIL reset_b i=%0d got=%h want=0", i, {ib.cpu_ce, ib.running, ib.busy, ib.step_count});
      end
    end
    all_hi = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total += 2;
    if ({ia.cpu_ce, ia.step_count} !== 33'd0) begin
      bad++;
      $display("FAIL release_a got=%h want=0", {ia.cpu_ce, ia.step_count});
    end
    if ({ib.cpu_ce, ib.step_count} !== 5'd0) begin
      bad++;
      $display("FAIL release_b got=%h want=0", {ib.cpu_ce, ib.step_count});
    end
    e_cnt[0] = '0;
    e_cnt[1] = '0;
  endtask
  task automatic test_step();
    for (int i = 0; i < 20; i++) begin
      push(i % 5 == 0, 1'b0, 1'b0);
      step(i % 5 == 0, i == 1, 1'b0, i == 1);
      want = sb.pop_front();
      total++;
      if (obs !== want) begin bad++; $display("FAIL step i=%0d got=%h want=%h", i, obs, want); end
    end
  endtask
  task automatic test_burst();
    for (int i = 0; i < 20; i++) begin
      push(i <= 15, 1'b0, i <= 15);
      step(i == 5, i == 0 || i == 7, 1'b0, 1'b0);
      want = sb.pop_front();
      total++;
      if (obs !== want) begin bad++; $display("FAIL burst i=%0d got=%h want=%h", i, obs, want); end
    end
  endtask
  task automatic test_run_div();
    for (int i = 0; i < 16; i++) begin
      push(i <= 12 && (i + 1) % 4 == 0, i <= 12, 1'b0);
      step(i == 6, i == 7, i == 0 || i == 13, i == 1 || i == 2);
      want = sb.pop_front();
      total++;
      if (obs !== want) begin bad++; $display("FAIL run_div i=%0d got=%h want=%h", i, obs, want); end
    end
  endtask
  task automatic test_reset_abort();
    for (int i = 0; i < 7; i++) begin
      rst = (i == 3);
      if (i == 3) begin
        e_cnt[0] = '0;
        e_cnt[1] = '0;
      end
      push(i <= 2, 1'b0, i <= 2);
      step(1'b0, i == 0, 1'b0, 1'b0);
      want = sb.pop_front();
      total++;
      if (obs !== want) begin bad++; $display("FAIL reset_abort i=%0d got=%h want=%h", i, obs, want); end
    end
    rst = 1'b0;
  endtask
  task automatic test_brk();
    for (int i = 0; i < 4; i++) begin
      push(i == 0, i == 0, 1'b0);
      step(1'b0, 1'b0, i == 0, 1'b1);
      want = sb.pop_front();
      total++;
      if (obs !== want) begin bad++; $display("FAIL brk_run i=%0d got=%h want=%h", i, obs, want); end
    end
    for (int i = 0; i < 9; i++) begin
      push(i <= 4, 1'b0, i <= 4);
      step(1'b0, i == 0, 1'b0, i == 5);
      want = sb.pop_front();
      total++;
      if (obs !== want) begin bad++; $display("FAIL brk_burst i=%0d got=%h want=%h", i, obs, want); end
    end
    for (int i = 0; i < 9; i++) begin
      push(i <= 4, i >= 2 && i <= 4, i <= 1);
      step(1'b0, i == 0, i == 2 || i == 5, i == 5);
      want = sb.pop_front();
      total++;
      if (obs !== want) begin bad++; $display("FAIL burst_to_run i=%0d got=%h want=%h", i, obs, want); end
    end
    for (int i = 0; i < 6; i++) begin
      push(i <= 1, 1'b0, i <= 1);
      step(1'b0, i == 0, i == 2, i == 2);
      want = sb.pop_front();
      total++;
      if (obs !== want) begin bad++; $display("FAIL brk_over_run i=%0d got=%h want=%h", i, obs, want); end
    end
  endtask
  task automatic test_priority();
    for (int i = 0; i < 6; i++) begin
      push(i <= 2, i <= 2, 1'b0);
      step(i <= 1, 1'b0, i == 0 || i == 3, 1'b0);
      want = sb.pop_front();
      total++;
      if (obs !== want) begin bad++; $display("FAIL prio_run_step i=%0d got=%h want=%h", i, obs, want); end
    end
    for (int i = 0; i < 12; i++) begin
      push(i <= 7, 1'b0, i <= 7);
      step(i == 0, i == 0, 1'b0, 1'b0);
      want = sb.pop_front();
      total++;
      if (obs !== want) begin bad++; $display("FAIL prio_burst_step i=%0d got=%h want=%h", i, obs, want); end
    end
    for (int i = 0; i < 5; i++) begin
      push(i <= 1, i <= 1, 1'b0);
      step(1'b0, i == 0, i == 0 || i == 2, 1'b0);
      want = sb.pop_front();
      total++;
      if (obs !== want) begin bad++; $display("FAIL prio_run_burst i=%0d got=%h want=%h", i, obs, want); end
    end
  endtask
  task automatic test_wrap();
    for (int i = 0; i < 36; i++) begin
      push(i % 2 == 0 && i < 34, 1'b0, 1'b0);
      step(i % 2 == 0 && i < 34, 1'b0, 1'b0, 1'b0);
      want = sb.pop_front();
      total++;
      if (obs !== want) begin bad++; $display("FAIL wrap i=%0d got=%h want=%h", i, obs, want); end
    end
  endtask
  initial begin
    e_cnt[0] = '0;
    e_cnt[1] = '0;
    test_reset();
    sel = 1'b0;
    #1;
    test_step();
    test_burst();
    test_run_div();
    test_reset_abort();
    sel = 1'b1;
    #1;
    test_brk();
    test_priority();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
Run-control stage directly downstream of the push-button debounce stage on the Basys3 board. Consumes single-cycle button pulses and produces the clock-enable that advances the RV32I core. Supports four behaviours: single step, fixed-length burst, free run with a divider, and halt on breakpoint. Also keeps a count of issued core cycles for the display logic.

Parameters:
BURST_LEN, 16, number of consecutive core enables per burst; legal range 1..65535.
RUN_DIV, 1, free-run enable period in clk cycles (1 = every cycle); legal range 1..2^24.
CNT_W, 32, width of step_count.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous reset, active-high.
step_pulse  input  1  one-cycle pulse from the debounce stage; request one core step.
burst_pulse  input  1  one-cycle pulse; request BURST_LEN core steps.
run_pulse  input  1  one-cycle pulse; toggles between free-run and halt.
brk_hit  input  1  level from the core; PC matches the breakpoint.
cpu_ce  output  1  registered core clock-enable.
running  output  1  registered; high while in RUN.
busy  output  1  registered; high while in BURST.
step_count  output  CNT_W  number of cycles in which cpu_ce has been high; wraps modulo 2^CNT_W.

Behaviour:
- Reset: state=IDLE, cpu_ce=0, running=0, busy=0, step_count=0, burst counter=0, divider=0. Reset asserted mid-burst or mid-run aborts immediately. No cpu_ce is issued after the reset edge.
- States: IDLE (halted), STEP, BURST, RUN. All outputs are registered. Pulses sampled in cycle t take effect at t+1.
- IDLE, simultaneous pulses: priority is run_pulse > burst_pulse > step_pulse. Lower-priority pulses in the same cycle are dropped.
- IDLE + step_pulse at t: STEP at t+1 with cpu_ce=1 for exactly that one cycle. IDLE at t+2.
- STEP: all pulses are ignored.
- IDLE + burst_pulse at t: BURST from t+1. cpu_ce=1 and busy=1 for BURST_LEN consecutive cycles, t+1..t+BURST_LEN. IDLE at t+BURST_LEN+1.
- BURST: step_pulse and burst_pulse are ignored. run_pulse at t goes to RUN at t+1, and the burst counter is discarded.
- IDLE + run_pulse at t: RUN from t+1 with running=1 and divider cleared. cpu_ce=1 at t+RUN_DIV, t+2*RUN_DIV, and so on. With RUN_DIV=1, cpu_ce is high every cycle from t+1.
- RUN: step_pulse and burst_pulse are ignored. run_pulse at t goes to IDLE at t+1, with cpu_ce=0 and running=0 from t+1.
- brk_hit handling:
  - Honoured only in RUN/BURST, and only after at least one cpu_ce has been issued in the current RUN/BURST episode. This lets the user resume off a breakpoint.
  - When honoured at t: IDLE at t+1, cpu_ce=0, running=0, busy=0.
  - If a run_pulse arrives in the same cycle, brk_hit takes precedence. Both lead to IDLE.
  - In IDLE/STEP, brk_hit is ignored, so single step always works.
- step_count increments by 1 in the cycle after each cycle with cpu_ce=1. It wraps from 2^CNT_W-1 to 0 with no flag.
- Burst counter width is 16 bits. Divider width is 24 bits. Both clear on every entry into BURST/RUN.

Test Plan:
- Reset with pulses held high → all outputs 0 for every reset cycle. First cycle after release: cpu_ce=0, step_count=0.
- IDLE, step_pulse at cycle 10 → cpu_ce high at cycle 11 only; step_count=1 at cycle 12. Three more step pulses spaced 5 cycles apart → step_count=4.
- BURST_LEN=16, burst_pulse at cycle 20 → cpu_ce and busy high cycles 21..36, low at 37; step_count=16. A step_pulse at cycle 25 changes nothing.
- RUN_DIV=4, run_pulse at cycle 0 → cpu_ce at cycles 4, 8, 12, ... Second run_pulse at cycle 13 → no cpu_ce from 14; running=0; step_count=3.
- RUN_DIV=1, brk_hit held high before run_pulse at cycle 0 → cpu_ce at cycle 1 only; IDLE at cycle 2; step_count=1. brk_hit raised at cycle 30 during a burst started at cycle 25 → cpu_ce last high at cycle 30, busy=0 at cycle 31.
- CNT_W=4, 17 single steps → step_count wraps to 1. Simultaneous run_pulse + step_pulse in IDLE → RUN entered, no STEP cycle.
